// File: rtl/tlk2711_pkg.sv
// ----------------------------------------------------------------------------
// tlk2711_pkg
// Shared definitions for the TLK2711 configuration sequencer:
//   - register map of the tlk2711_top register port
//   - sequencer FSM state encoding
//   - TX mode encoding and pending-interrupt selector
// ----------------------------------------------------------------------------
package tlk2711_pkg;

    // Register map (16-bit addresses on the register port)
    localparam logic [15:0] TX_START   = 16'h0100;
    localparam logic [15:0] TX_BASE    = 16'h0108;
    localparam logic [15:0] TX_TOTAL   = 16'h0110;
    localparam logic [15:0] TX_LEN     = 16'h0118;
    localparam logic [15:0] TX_CFG     = 16'h0120;
    localparam logic [15:0] RX_START   = 16'h0200;
    localparam logic [15:0] RX_BASE    = 16'h0208;
    localparam logic [15:0] IRQ_STATUS = 16'h0100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_WR,
        ST_RX_WR,
        ST_IRQ_RD,
        ST_IRQ_WAIT
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORM     = 2'd0,
        MODE_LOOPBACK = 2'd1,
        MODE_KCODE    = 2'd2
    } tx_mode_t;

    // Which pending interrupt the next status read will consume
    typedef enum logic [1:0] {
        IRQ_NONE,
        IRQ_LOSS,
        IRQ_RX,
        IRQ_TX
    } irq_sel_t;

endpackage

// File: rtl/tlk2711_cfg_seq_if.sv
// ----------------------------------------------------------------------------
// tlk2711_cfg_seq_if
// Register port between the configuration sequencer (master) and the
// tlk2711_top register block (slave).
//   o_reg_wen/o_reg_waddr/o_reg_wdata : write strobe, address, data
//   o_reg_ren/o_reg_raddr             : read strobe, address
//   i_reg_rdata                       : read data, valid RD_LATENCY cycles
//                                       after the read strobe
// ----------------------------------------------------------------------------
interface tlk2711_cfg_seq_if #(
    parameter int REG_ADDR_WIDTH = 16,
    parameter int REG_DATA_WIDTH = 64
);
    logic                      o_reg_wen;
    logic [REG_ADDR_WIDTH-1:0] o_reg_waddr;
    logic [REG_DATA_WIDTH-1:0] o_reg_wdata;
    logic                      o_reg_ren;
    logic [REG_ADDR_WIDTH-1:0] o_reg_raddr;
    logic [REG_DATA_WIDTH-1:0] i_reg_rdata;

    modport master (
        output o_reg_wen, o_reg_waddr, o_reg_wdata, o_reg_ren, o_reg_raddr,
        input  i_reg_rdata
    );

    modport slave (
        input  o_reg_wen, o_reg_waddr, o_reg_wdata, o_reg_ren, o_reg_raddr,
        output i_reg_rdata
    );
endinterface

// File: rtl/tlk2711_irq_latch.sv
// ----------------------------------------------------------------------------
// tlk2711_irq_latch
// Rising-edge detect on the three link interrupts plus one pending bit each.
// An edge on an already-pending bit merges into it. o_sel names the bit the
// next status read will consume (loss > rx > tx); i_consume clears it.
//   clk, rst_n                      : clock, async active-low reset
//   i_tx_irq, i_rx_irq, i_loss_irq  : link interrupts (level or pulse)
//   i_consume                       : clear the bit currently named by o_sel
//   o_pend_any                      : at least one bit pending
//   o_sel                           : highest-priority pending bit
// ----------------------------------------------------------------------------
module tlk2711_irq_latch
    import tlk2711_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_tx_irq,
    input  logic     i_rx_irq,
    input  logic     i_loss_irq,
    input  logic     i_consume,
    output logic     o_pend_any,
    output irq_sel_t o_sel
);
    // Bit order: [2] loss, [1] rx, [0] tx
    logic [2:0] r_prev;
    logic [2:0] r_pend;
    logic [2:0] w_irq;
    logic [2:0] w_rise;
    logic [2:0] w_sel_mask;
    logic [2:0] w_clr;

    assign w_irq      = {i_loss_irq, i_rx_irq, i_tx_irq};
    assign w_rise     = w_irq & ~r_prev;
    assign o_pend_any = |r_pend;
    assign w_clr      = i_consume ? w_sel_mask : 3'b000;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered path would infer a latch.
        o_sel      = IRQ_NONE;
        w_sel_mask = 3'b000;
        if (r_pend[2]) begin
            o_sel      = IRQ_LOSS;
            w_sel_mask = 3'b100;
        end else if (r_pend[1]) begin
            o_sel      = IRQ_RX;
            w_sel_mask = 3'b010;
        end else if (r_pend[0]) begin
            o_sel      = IRQ_TX;
            w_sel_mask = 3'b001;
        end
    end

    // A new edge on the bit being consumed in the same cycle survives, so
    // that event still gets its own status read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 3'b000;
            r_pend <= 3'b000;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every flop samples the pre-edge value of its inputs.
            r_prev <= w_irq;
            r_pend <= (r_pend & ~w_clr) | w_rise;
        end
    end
endmodule

// File: rtl/tlk2711_cfg_seq.sv
// ----------------------------------------------------------------------------
// tlk2711_cfg_seq
// Register-programming sequencer for the TLK2711 link. Turns TX-job and
// RX-arm requests into ordered register write bursts, services the latched
// link interrupts with a status read, and runs a TX completion watchdog.
//   clk, rst_n            : clock, async active-low reset
//   i_tx_req / o_tx_ack   : TX job handshake; fields sampled in the ack cycle
//   i_tx_*                : TX job fields (base, total, body, tail, num, mode)
//   i_rx_req / o_rx_ack   : RX arm handshake; i_rx_base_addr sampled on ack
//   reg_bus               : register port (master side)
//   i_tx/rx/loss_irq      : link interrupts
//   o_tx_busy             : TX job started and not yet serviced/timed out
//   o_tx_done/o_rx_done/o_loss : one-cycle pulses with the new o_irq_status
//   o_irq_status          : last status word read
//   o_tx_timeout          : one-cycle watchdog pulse
// All outputs are registered.
// ----------------------------------------------------------------------------
module tlk2711_cfg_seq
    import tlk2711_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 16,
    parameter int REG_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 48,
    parameter int RD_LATENCY     = 1,        // 1..4
    parameter int TX_TIMEOUT     = 1000000   // >= 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_tx_req,
    output logic                      o_tx_ack,
    input  logic [ADDR_WIDTH-1:0]     i_tx_base_addr,
    input  logic [31:0]               i_tx_total,
    input  logic [31:0]               i_tx_body,
    input  logic [31:0]               i_tx_tail,
    input  logic [31:0]               i_tx_body_num,
    input  logic [1:0]                i_tx_mode,
    input  logic                      i_rx_req,
    output logic                      o_rx_ack,
    input  logic [ADDR_WIDTH-1:0]     i_rx_base_addr,
    tlk2711_cfg_seq_if.master         reg_bus,
    input  logic                      i_tx_irq,
    input  logic                      i_rx_irq,
    input  logic                      i_loss_irq,
    output logic                      o_tx_busy,
    output logic                      o_tx_done,
    output logic                      o_rx_done,
    output logic                      o_loss,
    output logic [REG_DATA_WIDTH-1:0] o_irq_status,
    output logic                      o_tx_timeout
);
    localparam int         WD_W    = $clog2(TX_TIMEOUT + 1);
    localparam logic [2:0] TX_LAST = 3'd5;   // step 0 = ack, 1..5 = writes
    localparam logic [2:0] RX_LAST = 3'd2;   // step 0 = ack, 1..2 = writes

    state_t r_state, w_next_state;
    logic [2:0] r_step, w_next_step;
    logic [2:0] r_lat, w_next_lat;
    logic       w_capture;

    logic                      w_pend_any;
    irq_sel_t                  w_sel;

    logic                      w_wen, w_ren, w_tx_ack, w_rx_ack;
    logic [REG_ADDR_WIDTH-1:0] w_waddr, w_raddr;
    logic [REG_DATA_WIDTH-1:0] w_wdata;

    logic                      r_wen, r_ren, r_tx_ack, r_rx_ack;
    logic [REG_ADDR_WIDTH-1:0] r_waddr, r_raddr;
    logic [REG_DATA_WIDTH-1:0] r_wdata, r_irq_status;
    logic                      r_tx_busy, r_tx_done, r_rx_done, r_loss, r_tx_timeout;
    logic [WD_W-1:0]           r_wd;
    logic [31:0]               r_tx_total, r_tx_body, r_tx_tail, r_tx_body_num;
    tx_mode_t                  r_tx_mode;

    tlk2711_irq_latch u_irq_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tx_irq   (i_tx_irq),
        .i_rx_irq   (i_rx_irq),
        .i_loss_irq (i_loss_irq),
        .i_consume  (w_capture),
        .o_pend_any (w_pend_any),
        .o_sel      (w_sel)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_step  <= 3'd0;
            r_lat   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
            r_lat   <= w_next_lat;
        end
    end

    // FSM next state
    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step;
        w_next_lat   = r_lat;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_step = 3'd0;
                w_next_lat  = 3'd0;
                if (w_pend_any)                  w_next_state = ST_IRQ_RD;
                else if (i_tx_req && !r_tx_busy) w_next_state = ST_TX_WR;
                else if (i_rx_req)               w_next_state = ST_RX_WR;
            end
            ST_TX_WR: begin
                if (r_step == TX_LAST) w_next_state = ST_IDLE;
                else                   w_next_step  = r_step + 3'd1;
            end
            ST_RX_WR: begin
                if (r_step == RX_LAST) w_next_state = ST_IDLE;
                else                   w_next_step  = r_step + 3'd1;
            end
            ST_IRQ_RD: begin
                w_next_state = ST_IRQ_WAIT;
                w_next_lat   = 3'd1;
            end
            ST_IRQ_WAIT: begin
                // i_reg_rdata is valid in the RD_LATENCY-th cycle after ren
                if (r_lat == 3'(RD_LATENCY)) begin
                    w_next_state = ST_IDLE;
                    w_capture    = 1'b1;
                end else begin
                    w_next_lat = r_lat + 3'd1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so the strobes can be
    // registered without adding a cycle. The base address goes out straight
    // from the ack-cycle sample; the other fields are latched in that cycle.
    always_comb begin
        w_wen    = 1'b0;
        w_waddr  = '0;
        w_wdata  = '0;
        w_ren    = 1'b0;
        w_raddr  = '0;
        w_tx_ack = 1'b0;
        w_rx_ack = 1'b0;
        case (w_next_state)
            ST_TX_WR: begin
                case (w_next_step)
                    3'd0: w_tx_ack = 1'b1;
                    3'd1: begin
                        w_wen   = 1'b1;
                        w_waddr = REG_ADDR_WIDTH'(TX_BASE);
                        w_wdata = REG_DATA_WIDTH'(i_tx_base_addr);
                    end
                    3'd2: begin
                        w_wen   = 1'b1;
                        w_waddr = REG_ADDR_WIDTH'(TX_TOTAL);
                        w_wdata = REG_DATA_WIDTH'(r_tx_total);
                    end
                    3'd3: begin
                        w_wen   = 1'b1;
                        w_waddr = REG_ADDR_WIDTH'(TX_LEN);
                        w_wdata = REG_DATA_WIDTH'({r_tx_tail, r_tx_body});
                    end
                    3'd4: begin
                        w_wen   = 1'b1;
                        w_waddr = REG_ADDR_WIDTH'(TX_CFG);
                        w_wdata = REG_DATA_WIDTH'({r_tx_body_num, 30'd0, r_tx_mode});
                    end
                    3'd5: begin
                        w_wen   = 1'b1;
                        w_waddr = REG_ADDR_WIDTH'(TX_START);
                    end
                    default: ;
                endcase
            end
            ST_RX_WR: begin
                case (w_next_step)
                    3'd0: w_rx_ack = 1'b1;
                    3'd1: begin
                        w_wen   = 1'b1;
                        w_waddr = REG_ADDR_WIDTH'(RX_BASE);
                        w_wdata = REG_DATA_WIDTH'(i_rx_base_addr);
                    end
                    3'd2: begin
                        w_wen   = 1'b1;
                        w_waddr = REG_ADDR_WIDTH'(RX_START);
                    end
                    default: ;
                endcase
            end
            ST_IRQ_RD: begin
                w_ren   = 1'b1;
                w_raddr = REG_ADDR_WIDTH'(IRQ_STATUS);
            end
            default: ;
        endcase
    end

    // Output registers, TX field latch, watchdog and status capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen         <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_ren         <= 1'b0;
            r_raddr       <= '0;
            r_tx_ack      <= 1'b0;
            r_rx_ack      <= 1'b0;
            r_tx_busy     <= 1'b0;
            r_tx_done     <= 1'b0;
            r_rx_done     <= 1'b0;
            r_loss        <= 1'b0;
            r_tx_timeout  <= 1'b0;
            r_irq_status  <= '0;
            r_wd          <= '0;
            r_tx_total    <= '0;
            r_tx_body     <= '0;
            r_tx_tail     <= '0;
            r_tx_body_num <= '0;
            r_tx_mode     <= MODE_NORM;
        end else begin
            r_wen        <= w_wen;
            r_waddr      <= w_waddr;
            r_wdata      <= w_wdata;
            r_ren        <= w_ren;
            r_raddr      <= w_raddr;
            r_tx_ack     <= w_tx_ack;
            r_rx_ack     <= w_rx_ack;
            r_tx_done    <= 1'b0;
            r_rx_done    <= 1'b0;
            r_loss       <= 1'b0;
            r_tx_timeout <= 1'b0;

            if (r_state == ST_TX_WR && r_step == 3'd0) begin
                r_tx_total    <= i_tx_total;
                r_tx_body     <= i_tx_body;
                r_tx_tail     <= i_tx_tail;
                r_tx_body_num <= i_tx_body_num;
                r_tx_mode     <= tx_mode_t'(i_tx_mode);
            end

            // Loaded with TX_TIMEOUT-1 so the pulse lands exactly TX_TIMEOUT
            // cycles after the start write.
            if (r_tx_busy) begin
                if (r_wd <= WD_W'(1)) begin
                    r_tx_timeout <= 1'b1;
                    r_tx_busy    <= 1'b0;
                    r_wd         <= '0;
                end else begin
                    r_wd <= r_wd - WD_W'(1);
                end
            end

            if (r_state == ST_TX_WR && r_step == TX_LAST) begin
                r_tx_busy <= 1'b1;
                r_wd      <= WD_W'(TX_TIMEOUT - 1);
            end

            if (w_capture) begin
                r_irq_status <= reg_bus.i_reg_rdata;
                case (w_sel)
                    IRQ_LOSS: r_loss    <= 1'b1;
                    IRQ_RX:   r_rx_done <= 1'b1;
                    IRQ_TX: begin
                        r_tx_done <= 1'b1;
                        r_tx_busy <= 1'b0;
                        r_wd      <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign reg_bus.o_reg_wen   = r_wen;
    assign reg_bus.o_reg_waddr = r_waddr;
    assign reg_bus.o_reg_wdata = r_wdata;
    assign reg_bus.o_reg_ren   = r_ren;
    assign reg_bus.o_reg_raddr = r_raddr;
    assign o_tx_ack     = r_tx_ack;
    assign o_rx_ack     = r_rx_ack;
    assign o_tx_busy    = r_tx_busy;
    assign o_tx_done    = r_tx_done;
    assign o_rx_done    = r_rx_done;
    assign o_loss       = r_loss;
    assign o_irq_status = r_irq_status;
    assign o_tx_timeout = r_tx_timeout;
endmodule

// File: tb/tb_tlk2711_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_tlk2711_cfg_seq
// Directed bench for tlk2711_cfg_seq with RD_LATENCY=2 and TX_TIMEOUT=50.
// A small responder returns the bench-chosen status word RD_LATENCY cycles
// after each read strobe. Outputs are sampled 1 time unit after the edge.
// ----------------------------------------------------------------------------
module tb_tlk2711_cfg_seq;
    localparam int RD_LAT = 2;
    localparam int TX_TO  = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_tx_req = 1'b0, i_rx_req = 1'b0;
    logic [47:0] i_tx_base_addr = '0, i_rx_base_addr = '0;
    logic [31:0] i_tx_total = '0, i_tx_body = '0, i_tx_tail = '0, i_tx_body_num = '0;
    logic [1:0]  i_tx_mode = '0;
    logic        i_tx_irq = 1'b0, i_rx_irq = 1'b0, i_loss_irq = 1'b0;
    logic        o_tx_ack, o_rx_ack, o_tx_busy, o_tx_done, o_rx_done, o_loss, o_tx_timeout;
    logic [63:0] o_irq_status;
    logic [63:0] status_val = '0;
    logic [63:0] rd_pipe [RD_LAT];

    int n_checks = 0;
    int n_errors = 0;
    int n_bus    = 0;

    tlk2711_cfg_seq_if #(.REG_ADDR_WIDTH(16), .REG_DATA_WIDTH(64)) bus ();

    tlk2711_cfg_seq #(
        .REG_ADDR_WIDTH(16), .REG_DATA_WIDTH(64), .ADDR_WIDTH(48),
        .RD_LATENCY(RD_LAT), .TX_TIMEOUT(TX_TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_tx_req       (i_tx_req),
        .o_tx_ack       (o_tx_ack),
        .i_tx_base_addr (i_tx_base_addr),
        .i_tx_total     (i_tx_total),
        .i_tx_body      (i_tx_body),
        .i_tx_tail      (i_tx_tail),
        .i_tx_body_num  (i_tx_body_num),
        .i_tx_mode      (i_tx_mode),
        .i_rx_req       (i_rx_req),
        .o_rx_ack       (o_rx_ack),
        .i_rx_base_addr (i_rx_base_addr),
        .reg_bus        (bus.master),
        .i_tx_irq       (i_tx_irq),
        .i_rx_irq       (i_rx_irq),
        .i_loss_irq     (i_loss_irq),
        .o_tx_busy      (o_tx_busy),
        .o_tx_done      (o_tx_done),
        .o_rx_done      (o_rx_done),
        .o_loss         (o_loss),
        .o_irq_status   (o_irq_status),
        .o_tx_timeout   (o_tx_timeout)
    );

    always #5 clk = ~clk;

    // Status register responder: zero except RD_LAT cycles after a read
    always @(posedge clk) begin
        rd_pipe[0] <= bus.o_reg_ren ? status_val : 64'd0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.i_reg_rdata = rd_pipe[RD_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [15:0] addr, input logic [63:0] data);
        check({tag, " wen"}, 64'(bus.o_reg_wen), 64'd1);
        check({tag, " ren"}, 64'(bus.o_reg_ren), 64'd0);
        check({tag, " waddr"}, 64'(bus.o_reg_waddr), 64'(addr));
        check({tag, " wdata"}, bus.o_reg_wdata, data);
    endtask

    task automatic set_tx(input logic [47:0] base, input logic [31:0] total, input logic [31:0] body,
                          input logic [31:0] tail, input logic [31:0] num, input logic [1:0] mode);
        i_tx_base_addr = base;
        i_tx_total     = total;
        i_tx_body      = body;
        i_tx_tail      = tail;
        i_tx_body_num  = num;
        i_tx_mode      = mode;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst wen", 64'(bus.o_reg_wen), 64'd0);
        check("rst ren", 64'(bus.o_reg_ren), 64'd0);
        check("rst waddr", 64'(bus.o_reg_waddr), 64'd0);
        check("rst tx_ack", 64'(o_tx_ack), 64'd0);
        check("rst busy", 64'(o_tx_busy), 64'd0);
        check("rst status", o_irq_status, 64'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- TX job: 1800 / 870 / 60 / 2, mode 0 ----------------
        set_tx(48'h0, 32'd1800, 32'd870, 32'd60, 32'd2, 2'd0);
        i_tx_req = 1'b1;
        tick();
        check("tx1 ack", 64'(o_tx_ack), 64'd1);
        check("tx1 ack no wen", 64'(bus.o_reg_wen), 64'd0);
        i_tx_req = 1'b0;
        tick(); check_wr("tx1 base",  16'h0108, 64'h0);
        tick(); check_wr("tx1 total", 16'h0110, 64'd1800);
        tick(); check_wr("tx1 len",   16'h0118, 64'h0000003C_00000366);
        tick(); check_wr("tx1 cfg",   16'h0120, 64'h00000002_00000000);
        tick(); check_wr("tx1 start", 16'h0100, 64'h0);
        check("tx1 busy at start", 64'(o_tx_busy), 64'd0);
        tick();
        check("tx1 busy after", 64'(o_tx_busy), 64'd1);
        check("tx1 wen after", 64'(bus.o_reg_wen), 64'd0);

        // ---------------- tx irq, status 0x5 ----------------
        status_val = 64'h5;
        i_tx_irq = 1'b1;
        tick();
        i_tx_irq = 1'b0;
        tick();
        check("irq ren", 64'(bus.o_reg_ren), 64'd1);
        check("irq raddr", 64'(bus.o_reg_raddr), 64'h0100);
        check("irq no wen", 64'(bus.o_reg_wen), 64'd0);
        tick();
        check("irq ren one cycle", 64'(bus.o_reg_ren), 64'd0);
        tick();
        check("irq done early", 64'(o_tx_done), 64'd0);
        tick();
        check("irq status", o_irq_status, 64'h5);
        check("irq tx_done", 64'(o_tx_done), 64'd1);
        check("irq busy cleared", 64'(o_tx_busy), 64'd0);
        tick();
        check("irq tx_done pulse", 64'(o_tx_done), 64'd0);

        // ---------------- simultaneous TX and RX requests ----------------
        set_tx(48'h1234_5678_9ABC, 32'd64, 32'd32, 32'd16, 32'd1, 2'd2);
        i_rx_base_addr = 48'h100;
        i_tx_req = 1'b1;
        i_rx_req = 1'b1;
        tick();
        check("both tx_ack", 64'(o_tx_ack), 64'd1);
        check("both no rx_ack", 64'(o_rx_ack), 64'd0);
        i_tx_req = 1'b0;
        tick(); check_wr("tx2 base",  16'h0108, 64'h0000_1234_5678_9ABC);
        tick(); check_wr("tx2 total", 16'h0110, 64'd64);
        tick(); check_wr("tx2 len",   16'h0118, 64'h00000010_00000020);
        tick(); check_wr("tx2 cfg",   16'h0120, 64'h00000001_00000002);
        tick(); check_wr("tx2 start", 16'h0100, 64'h0);
        tick();
        check("rx waits", 64'(o_rx_ack), 64'd0);
        tick();
        check("rx ack", 64'(o_rx_ack), 64'd1);
        i_rx_req = 1'b0;
        tick(); check_wr("rx base",  16'h0208, 64'h100);
        tick(); check_wr("rx start", 16'h0200, 64'h0);
        tick();
        check("rx burst end", 64'(bus.o_reg_wen), 64'd0);

        // ---------------- loss and tx irq together ----------------
        status_val = 64'h4;
        i_loss_irq = 1'b1;
        i_tx_irq   = 1'b1;
        tick();
        i_loss_irq = 1'b0;
        i_tx_irq   = 1'b0;
        tick();
        check("dual read1 ren", 64'(bus.o_reg_ren), 64'd1);
        tick();
        tick();
        tick();
        check("dual loss", 64'(o_loss), 64'd1);
        check("dual read1 no tx_done", 64'(o_tx_done), 64'd0);
        check("dual read1 status", o_irq_status, 64'h4);
        check("dual busy held", 64'(o_tx_busy), 64'd1);
        status_val = 64'h1;
        tick();
        check("dual read2 ren", 64'(bus.o_reg_ren), 64'd1);
        tick();
        tick();
        tick();
        check("dual tx_done", 64'(o_tx_done), 64'd1);
        check("dual read2 no loss", 64'(o_loss), 64'd0);
        check("dual read2 status", o_irq_status, 64'h1);
        check("dual busy cleared", 64'(o_tx_busy), 64'd0);

        // ---------------- watchdog, TX_TIMEOUT = 50 ----------------
        set_tx(48'hABC, 32'd100, 32'd50, 32'd10, 32'd3, 2'd1);
        i_tx_req = 1'b1;
        tick();
        check("wd ack", 64'(o_tx_ack), 64'd1);
        i_tx_req = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check_wr("wd start", 16'h0100, 64'h0);
        n_bus = 0;
        for (int i = 0; i < TX_TO - 1; i++) begin
            tick();
            if (bus.o_reg_wen || bus.o_reg_ren || o_tx_timeout) n_bus++;
        end
        check("wd not yet", 64'(o_tx_timeout), 64'd0);
        check("wd busy held", 64'(o_tx_busy), 64'd1);
        tick();
        check("wd timeout", 64'(o_tx_timeout), 64'd1);
        check("wd busy cleared", 64'(o_tx_busy), 64'd0);
        check("wd quiet bus", 64'(n_bus), 64'd0);
        i_tx_req = 1'b1;
        tick();
        check("wd new ack", 64'(o_tx_ack), 64'd1);
        check("wd pulse one cycle", 64'(o_tx_timeout), 64'd0);
        i_tx_req = 1'b0;

        // ---------------- reset during third write ----------------
        tick();
        tick();
        tick();
        check_wr("rst3 third", 16'h0118, 64'h0000000A_00000032);
        rst_n = 1'b0;
        #1;
        check("rst3 wen", 64'(bus.o_reg_wen), 64'd0);
        check("rst3 waddr", 64'(bus.o_reg_waddr), 64'd0);
        check("rst3 wdata", bus.o_reg_wdata, 64'd0);
        check("rst3 status", o_irq_status, 64'd0);
        check("rst3 busy", 64'(o_tx_busy), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n_bus = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.o_reg_wen || bus.o_reg_ren || o_tx_ack) n_bus++;
        end
        check("rst3 no residual", 64'(n_bus), 64'd0);
        check("rst3 busy after", 64'(o_tx_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
